regfile_sb: RTL and testbench

Parametrised integer register file with multiple combinational read ports, one write port, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode/issue and writeback in the NPC core. Issue allocates destination registers, writeback retires them, and read ports report data plus a busy flag so hazard logic can stall without a separate scoreboard.

---
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD combinational read ports, one
// write (writeback) port, same-cycle write-to-read bypass and a per-register
// pending-write counter, so hazard logic reads data and busy in one lookup.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   re_i / raddr_i      per-port read enable and address (port k: [k*AW +: AW])
//   rdata_o / rbusy_o   per-port read data (port k: [k*XLEN +: XLEN]) and busy
//   we_i/waddr_i/wdata_i  writeback; retires one pending write
//   alloc_i/alloc_addr_i  issue-side allocation of a destination register
//   alloc_ready_o       allocation can be accepted this cycle
//   err_o               sticky: a write hit a register with no pending writes
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int PW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      re_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic                alloc_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic                alloc_ready_o,
  output logic                err_o
);

  localparam logic [PW-1:0] CMAX = '1;

  logic [XLEN-1:0] regs [NREG];
  logic [PW-1:0]   cnt  [NREG];
  logic            err_q;

  // Real storage lives at 1..NREG-1; x0 and out-of-range addresses are inert.
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREG)) && (a != '0);
  endfunction

  logic wr_ok, al_live, al_full, alloc_acc;

  assign wr_ok   = we_i && live(waddr_i);
  assign al_live = live(alloc_addr_i);
  assign al_full = al_live && (cnt[alloc_addr_i] == CMAX);
  // A saturated counter may still take an allocation when the same register
  // retires a write this cycle: the net counter change is zero.
  assign alloc_ready_o = !(al_full && !(wr_ok && (waddr_i == alloc_addr_i)));
  assign alloc_acc     = alloc_i && alloc_ready_o && al_live;
  assign err_o         = err_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          on, hit_w, hit_a;
    logic [PW:0]   pend;

    assign a     = raddr_i[k*AW +: AW];
    assign on    = re_i[k] && live(a);
    assign hit_w = wr_ok && (waddr_i == a);
    assign hit_a = alloc_acc && (alloc_addr_i == a);
    // Look-ahead pending count. A write to an idle register (err path) does
    // not decrement unless a same-cycle allocation offsets it.
    assign pend  = {1'b0, cnt[a]} + (PW+1)'(hit_a)
                 - (PW+1)'(hit_w && ((cnt[a] != '0) || hit_a));

    assign rdata_o[k*XLEN +: XLEN] = !on ? '0 : (hit_w ? wdata_i : regs[a]);
    assign rbusy_o[k]              = on && (pend != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[waddr_i] <= wdata_i;
        if (cnt[waddr_i] == '0) err_q <= 1'b1;
      end
      for (int i = 1; i < NREG; i++) begin
        if (alloc_acc && (alloc_addr_i == AW'(i)) && !(wr_ok && (waddr_i == AW'(i))))
          cnt[i] <= cnt[i] + 1'b1;
        else if (wr_ok && (waddr_i == AW'(i)) && !(alloc_acc && (alloc_addr_i == AW'(i)))
                 && (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes hand-computed expectations
// into a queue; a monitor on the falling edge pops and compares them.
module tb_regfile_sb;
  localparam int XLEN = 64, NREG = 32, AW = 5, NRD = 2, PW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      re_i;
  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic                we_i;
  logic [AW-1:0]       waddr_i;
  logic [XLEN-1:0]     wdata_i;
  logic                alloc_i;
  logic [AW-1:0]       alloc_addr_i;
  logic                alloc_ready_o;
  logic                err_o;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .PW(PW)) dut (
    .clk(clk), .rst(rst), .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rbusy_o(rbusy_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .alloc_i(alloc_i), .alloc_addr_i(alloc_addr_i), .alloc_ready_o(alloc_ready_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;  // 0 rdata0, 1 rdata1, 2 busy0, 3 busy1, 4 ready, 5 err
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        e;
  logic [63:0] act;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = rdata_o[0*XLEN +: XLEN];
        1:       act = rdata_o[1*XLEN +: XLEN];
        2:       act = 64'(rbusy_o[0]);
        3:       act = 64'(rbusy_o[1]);
        4:       act = 64'(alloc_ready_o);
        default: act = 64'(err_o);
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string n, input int k, input logic [63:0] v);
    exp_t x;
    x.name = n; x.kind = k; x.val = v;
    sb.push_back(x);
  endtask

  // Advance one cycle, then apply a full input vector 1ns after the edge.
  task automatic drv(input logic [1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic we, input logic [AW-1:0] wa, input logic [63:0] wd,
                     input logic al, input logic [AW-1:0] aa);
    @(posedge clk); #1;
    re_i = re; raddr_i = {a1, a0};
    we_i = we; waddr_i = wa; wdata_i = wd;
    alloc_i = al; alloc_addr_i = aa;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    re_i = '0; we_i = 1'b0; alloc_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    re_i = 2'b11; raddr_i = {5'd5, 5'd5};
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    alloc_i = 1'b0; alloc_addr_i = '0;
    expect_v("reset_rdata0", 0, 64'h0);
    expect_v("reset_busy0", 2, 64'h0);
    expect_v("reset_ready", 4, 64'h1);
    expect_v("reset_err", 5, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Unallocated write to x5: port 1 sees the bypass, err rises next cycle.
    drv(2'b10, 5'd0, 5'd5, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0);
    expect_v("byp_x5", 1, 64'h1234);
    expect_v("byp_x5_busy", 3, 64'h0);
    expect_v("err_pre", 5, 64'h0);
    drv(2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("rd_x5", 0, 64'h1234);
    expect_v("rd_x5_busy", 2, 64'h0);
    expect_v("err_unalloc", 5, 64'h1);

    // Bypass on port 1, then x0 write is discarded.
    drv(2'b10, 5'd0, 5'd7, 1'b1, 5'd7, 64'hAA, 1'b0, 5'd0);
    expect_v("byp_x7", 1, 64'hAA);
    drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0);
    drv(2'b11, 5'd0, 5'd7, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("rd_x0", 0, 64'h0);
    expect_v("rd_x0_busy", 2, 64'h0);
    expect_v("rd_x7", 1, 64'hAA);
    expect_v("err_held", 5, 64'h1);

    // Scoreboard: two allocations of x3, two retiring writes.
    pulse_reset();
    drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3);
    expect_v("al3_ready", 4, 64'h1);
    expect_v("al3_busy_same", 2, 64'h1);
    expect_v("err_after_rst", 5, 64'h0);
    drv(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3);
    drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("x3_busy_2", 2, 64'h1);
    drv(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 64'h11, 1'b0, 5'd0);
    expect_v("x3_wr1_data", 0, 64'h11);
    expect_v("x3_wr1_busy", 2, 64'h1);
    drv(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 64'h22, 1'b0, 5'd0);
    expect_v("x3_wr2_data", 0, 64'h22);
    expect_v("x3_wr2_busy", 2, 64'h0);
    drv(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("x3_final", 0, 64'h22);
    expect_v("x3_final_busy", 2, 64'h0);
    expect_v("x3_err", 5, 64'h0);

    // Saturation of x9 at 3 pending writes.
    for (int i = 0; i < 3; i++)
      drv(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    drv(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    expect_v("x9_full_ready", 4, 64'h0);
    expect_v("x9_full_busy", 2, 64'h1);
    drv(2'b01, 5'd9, 5'd0, 1'b1, 5'd9, 64'h55, 1'b1, 5'd9);
    expect_v("x9_wr_al_ready", 4, 64'h1);
    expect_v("x9_wr_al_busy", 2, 64'h1);
    drv(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    expect_v("x9_still_full", 4, 64'h0);
    drv(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0);
    expect_v("x0_alloc_ready", 4, 64'h1);
    expect_v("x9_data", 0, 64'h55);
    expect_v("x9_err", 5, 64'h0);

    // Async reset mid-operation with x4 pending.
    drv(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd4);
    drv(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 64'hBEEF, 1'b1, 5'd4);
    drv(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("x4_data", 0, 64'hBEEF);
    expect_v("x4_busy", 2, 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_v("arst_rdata", 0, 64'h0);
    expect_v("arst_busy", 2, 64'h0);
    expect_v("arst_ready", 4, 64'h1);
    #5;
    rst = 1'b1;
    drv(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    expect_v("post_rst_x4", 0, 64'h0);
    expect_v("post_rst_busy", 2, 64'h0);
    expect_v("post_rst_err", 5, 64'h0);

    @(posedge clk); @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
